// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and frame FSM state type for the UART receiver.
// Defines UART_RX_PARITY_EN-dependent state list (PARITY state only when parity is enabled).
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 87;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: first-word fall-through synchronous FIFO for received bytes.
// Ports: clk, rst (async active-high), push/din write, pop read, dout = head (0 when empty), full, empty.
module uart_rx_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [W-1:0] mem_q [DEPTH];
  logic wr_en, rd_en;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rd_en = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en = push & (~full | rd_en);
  assign dout = empty ? '0 : mem_q[rd_q];
  always_comb begin
    wr_d = wr_en ? wr_q + PW'(1) : wr_q;
    rd_d = rd_en ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a FWFT byte FIFO.
// Ports: i_Clock, i_Reset (async active-high), i_Rx_Serial line, i_Rx_Ready pop;
//        o_Rx_DV/o_Rx_Byte FIFO head, o_Frame_Err/o_Parity_Err/o_Overflow pulses, o_Busy frame in progress.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_Serial,
  input  logic              i_Rx_Ready,
  output logic              o_Rx_DV,
  output logic [DATA_W-1:0] o_Rx_Byte,
  output logic              o_Frame_Err,
  output logic              o_Parity_Err,
  output logic              o_Overflow,
  output logic              o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  state_t state_q, state_d;
  logic rx_meta_q, rx_sync_q;
  logic [1:0] warm_q, warm_d;
  logic armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic frame_err_q, frame_err_d, ovf_q, ovf_d;
  logic push, pop, full, empty, par_ok;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, par_err_q, par_err_d;
  assign par_ok = ~^{data_q, par_q};
  assign o_Parity_Err = par_err_q;
`else
  assign par_ok = 1'b1;
  assign o_Parity_Err = 1'b0;
`endif
  assign o_Rx_DV = ~empty;
  assign pop = i_Rx_Ready & ~empty;
  assign o_Busy = state_q != S_IDLE;
  assign o_Frame_Err = frame_err_q;
  assign o_Overflow = ovf_q;
  // A start is only accepted after the line has been seen idle-high: this ignores a line
  // that is already low when reset releases (mid-frame) or right after a bad stop bit.
  // warm_q masks the two cycles where the synchronizer still holds its reset value.
  always_comb begin
    state_d = state_q;
    warm_d = {warm_q[0], 1'b1};
    armed_d = armed_q | (warm_q[1] & rx_sync_q);
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    data_d = data_q;
    push = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    par_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (armed_q && !rx_sync_q) state_d = S_START;
      end
      S_START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          data_d = {rx_sync_q, data_q[DATA_W-1:1]};
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          par_d = rx_sync_q;
          state_d = S_STOP;
        end
`endif
      S_STOP:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = S_IDLE;
          frame_err_d = !rx_sync_q;
`ifdef UART_RX_PARITY_EN
          par_err_d = !par_ok;
`endif
          push = rx_sync_q & par_ok;
          armed_d = rx_sync_q;
        end
      default: state_d = S_IDLE;
    endcase
    ovf_d = push & full & ~pop;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      warm_q <= '0;
      armed_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      frame_err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      warm_q <= warm_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      data_q <= data_d;
      frame_err_q <= frame_err_d;
      ovf_q <= ovf_d;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      par_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      par_err_q <= par_err_d;
    end
`endif
  uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk(i_Clock),
    .rst(i_Reset),
    .push(push),
    .pop(pop),
    .din(data_q),
    .dout(o_Rx_Byte),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven bench for uart_rx_fifo at 87 clocks per bit, depth 4.
module tb_uart_rx_fifo;
  localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
  localparam int PUSH_AT = 46 + 10 * CPB;
`else
  localparam int PUSH_AT = 46 + 9 * CPB;
`endif
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rdy = 1'b0;
  logic dv, fe, pe, ovf, busy;
  logic [7:0] rbyte;
  int errors = 0, checks = 0;
  int fe_cnt = 0, pe_cnt = 0, ovf_cnt = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Rx_Serial(rx),
    .i_Rx_Ready(rdy),
    .o_Rx_DV(dv),
    .o_Rx_Byte(rbyte),
    .o_Frame_Err(fe),
    .o_Parity_Err(pe),
    .o_Overflow(ovf),
    .o_Busy(busy)
  );
  always @(negedge clk) begin
    if (fe) fe_cnt++;
    if (pe) pe_cnt++;
    if (ovf) ovf_cnt++;
  end
  typedef struct {
    logic [7:0] data;
    logic stop;
    logic exp_dv;
    int exp_fe;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] d, input logic stop, input logic par);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_dv"}, int'(dv), 1);
    check({name, "_byte"}, int'(rbyte), int'(exp));
    rdy = 1'b1;
    @(negedge clk) rdy = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
  initial begin
    int fe0, pe0, ovf0, n;
    logic [7:0] c3;
    vecs[0] = '{8'h3F, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 0};
    repeat (3) @(negedge clk);
    check("rst_dv", int'(dv), 0);
    check("rst_byte", int'(rbyte), 0);
    check("rst_fe", int'(fe), 0);
    check("rst_pe", int'(pe), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // table of single frames, one at a time with the consumer stalled
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt; pe0 = pe_cnt; ovf0 = ovf_cnt;
      send_bits(vecs[v].data, vecs[v].stop, ^vecs[v].data);
      check($sformatf("vec%0d_dv", v), int'(dv), int'(vecs[v].exp_dv));
      if (vecs[v].exp_dv) check($sformatf("vec%0d_byte", v), int'(rbyte), int'(vecs[v].data));
      check($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d_pe", v), pe_cnt - pe0, 0);
      check($sformatf("vec%0d_ovf", v), ovf_cnt - ovf0, 0);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
      if (dv) begin
        rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
      end
      check($sformatf("vec%0d_empty", v), int'(dv), 0);
    end
    // latency of 0x3F from start edge to o_Rx_DV
    n = 0;
    fork
      send_bits(8'h3F, 1'b1, ^8'h3F);
      begin
        @(negedge clk);
        while (!dv && n < 3000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    check("lat_window", int'(n >= PUSH_AT - 9 && n <= PUSH_AT + 11), 1);
    pop_check("lat", 8'h3F);
    check("lat_once", int'(dv), 0);
    // start glitch: 20 clocks low
    fe0 = fe_cnt;
    @(negedge clk) rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_hi", int'(busy), 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB) @(negedge clk);
    check("glitch_busy_lo", int'(busy), 0);
    check("glitch_dv", int'(dv), 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    // overflow: 5 bytes into depth 4 without popping
    for (int k = 1; k <= 5; k++) begin
      ovf0 = ovf_cnt;
      send_bits(8'(k), 1'b1, ^(8'(k)));
      check($sformatf("ovf_byte%0d", k), ovf_cnt - ovf0, k == 5 ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) pop_check($sformatf("drain%0d", k), 8'(k));
    check("drain_empty", int'(dv), 0);
    // push and pop in the same cycle while full
    for (int k = 1; k <= 4; k++) send_bits(8'(k), 1'b1, ^(8'(k)));
    ovf0 = ovf_cnt;
    fork
      send_bits(8'h05, 1'b1, ^8'h05);
      begin
        @(negedge clk);
        repeat (PUSH_AT) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
      end
    join
    check("fullpp_ovf", ovf_cnt - ovf0, 0);
    for (int k = 2; k <= 5; k++) pop_check($sformatf("fullpp%0d", k), 8'(k));
    check("fullpp_empty", int'(dv), 0);
    // reset during bit 4 of 0xC3, then 0x5A
    c3 = 8'hC3;
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (CPB) @(negedge clk);
    end
    rx = c3[4];
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dv", int'(dv), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("midrst_idle", int'(busy), 0);
    send_bits(8'h5A, 1'b1, ^8'h5A);
    pop_check("midrst_5a", 8'h5A);
    check("midrst_only", int'(dv), 0);
`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_bits(8'h07, 1'b1, 1'b0);
    check("par_bad_pe", pe_cnt - pe0, 1);
    check("par_bad_fe", fe_cnt - fe0, 0);
    check("par_bad_dv", int'(dv), 0);
    pe0 = pe_cnt;
    send_bits(8'h07, 1'b1, 1'b1);
    check("par_ok_pe", pe_cnt - pe0, 0);
    pop_check("par_ok", 8'h07);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
